ili_frame_scheduler: RTL



---
 rtl/ili_pkg.sv | 39 +++
 rtl/ili_scale_addr_gen.sv | 98 +++++++++
 rtl/ili_frame_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ili_pkg.sv
// ============================================================================
// ili_pkg : shared types and constants for the ILI9341 frame scheduler
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ili_pkg;

    localparam int c_pixel_size   = 16;
    localparam int c_src_w        = 80;
    localparam int c_src_h        = 80;
    localparam int c_scale        = 3;
    localparam int c_n_img        = 5;
    localparam int c_img_pixels   = c_src_w * c_src_h;
    localparam int c_frame_pixels = (c_src_w * c_scale) * (c_src_h * c_scale);

    localparam logic [15:0] c_rgb_black = 16'h0000;
    localparam logic [15:0] c_rgb_white = 16'hFFFF;
    localparam logic [15:0] c_rgb_red   = 16'hF800;
    localparam logic [15:0] c_rgb_green = 16'h07E0;
    localparam logic [15:0] c_rgb_blue  = 16'h001F;

    typedef enum logic [2:0] {
        c_st_idle    = 3'd0,
        c_st_load    = 3'd1,
        c_st_fetch   = 3'd2,
        c_st_wait    = 3'd3,
        c_st_present = 3'd4,
        c_st_done    = 3'd5
    } state_t;

    // Counter width for a count that runs 0..n-1, never narrower than one bit.
    function automatic int ctr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ili_scale_addr_gen.sv
// ============================================================================
// ili_scale_addr_gen : column/row and horizontal/vertical replay counters
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ili_scale_addr_gen
    import ili_pkg::*;
#(
    parameter int SRC_W  = c_src_w,
    parameter int SRC_H  = c_src_h,
    parameter int SCALE  = c_scale,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              need_fetch,
    output logic              last
);

    localparam int c_col_w = ctr_w(SRC_W);
    localparam int c_row_w = ctr_w(SRC_H);
    localparam int c_rep_w = ctr_w(SCALE);

    localparam logic [c_col_w-1:0] c_col_max = c_col_w'(SRC_W - 1);
    localparam logic [c_row_w-1:0] c_row_max = c_row_w'(SRC_H - 1);
    localparam logic [c_rep_w-1:0] c_rep_max = c_rep_w'(SCALE - 1);
    localparam logic [ADDR_W-1:0]  c_row_len = ADDR_W'(SRC_W);

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic [c_rep_w-1:0] r_hrep;
    logic [c_rep_w-1:0] r_vrep;
    logic [ADDR_W-1:0]  r_row_base;
    logic [ADDR_W-1:0]  r_addr;

    logic w_hrep_end;
    logic w_col_end;
    logic w_vrep_end;
    logic w_row_end;

    assign w_hrep_end = (r_hrep == c_rep_max);
    assign w_col_end  = (r_col  == c_col_max);
    assign w_vrep_end = (r_vrep == c_rep_max);
    assign w_row_end  = (r_row  == c_row_max);

    assign last       = w_hrep_end && w_col_end && w_vrep_end && w_row_end;
    assign need_fetch = w_hrep_end && !last;
    assign addr       = r_addr;

    // r_addr always equals r_row_base + r_col, kept as its own register so the
    // ROM address is valid in the very cycle the FSM enters FETCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_hrep     <= '0;
            r_vrep     <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else if (start) begin
            r_col      <= '0;
            r_row      <= '0;
            r_hrep     <= '0;
            r_vrep     <= '0;
            r_row_base <= base;
            r_addr     <= base;
        end else if (advance) begin
            if (!w_hrep_end) begin
                r_hrep <= r_hrep + 1'b1;
            end else begin
                r_hrep <= '0;
                if (!w_col_end) begin
                    r_col  <= r_col + 1'b1;
                    r_addr <= r_addr + 1'b1;
                end else begin
                    r_col <= '0;
                    if (!w_vrep_end) begin
                        r_vrep <= r_vrep + 1'b1;
                        r_addr <= r_row_base;
                    end else if (!w_row_end) begin
                        r_vrep     <= '0;
                        r_row      <= r_row + 1'b1;
                        r_row_base <= r_row_base + c_row_len;
                        r_addr     <= r_row_base + c_row_len;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ili_frame_scheduler.sv
// ============================================================================
// ili_frame_scheduler : arbitrates redraw requests and streams upscaled frames
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ili_frame_scheduler
    import ili_pkg::*;
#(
    parameter int PIXEL_SIZE = c_pixel_size,
    parameter int SRC_W      = c_src_w,
    parameter int SRC_H      = c_src_h,
    parameter int SCALE      = c_scale,
    parameter int N_IMG      = c_n_img,
    parameter int ADDR_W     = $clog2(N_IMG * SRC_W * SRC_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_req,
    input  logic [2:0]            sel_id,
    input  logic                  refresh_tick,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [PIXEL_SIZE-1:0] rom_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [PIXEL_SIZE-1:0] pix_data,
    output logic                  pix_last,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  busy,
    output logic [2:0]            cur_img
);

    localparam logic [3:0]        c_n_img_v  = 4'(N_IMG);
    localparam logic [ADDR_W-1:0] c_img_size = ADDR_W'(SRC_W * SRC_H);

    state_t                r_state;
    state_t                w_next;
    logic                  r_pending;
    logic [2:0]            r_pend_id;
    logic [2:0]            r_load_id;
    logic [2:0]            r_cur_img;
    logic [PIXEL_SIZE-1:0] r_pix_data;

    logic                  w_sel_ok;
    logic                  w_consume;
    logic                  w_start;
    logic                  w_advance;
    logic                  w_need_fetch;
    logic                  w_last;
    logic [ADDR_W-1:0]     w_base;
    logic [ADDR_W-1:0]     w_addr;

    assign w_sel_ok = sel_req && ({1'b0, sel_id} < c_n_img_v);
    assign w_base   = ADDR_W'(r_load_id) * c_img_size;

    // A new request outranks the IDLE consume, so nothing arriving in that
    // cycle is lost; a tick only fills an empty (or just-emptied) slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_pend_id <= '0;
            r_load_id <= '0;
        end else begin
            if (w_sel_ok) begin
                r_pending <= 1'b1;
                r_pend_id <= sel_id;
            end else if (refresh_tick && (!r_pending || w_consume)) begin
                r_pending <= 1'b1;
                r_pend_id <= r_cur_img;
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end
            if (w_consume) begin
                r_load_id <= r_pend_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur_img  <= '0;
            r_pix_data <= '0;
        end else begin
            if (r_state == c_st_load) begin
                r_cur_img <= r_load_id;
            end
            if (r_state == c_st_wait) begin
                r_pix_data <= rom_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:    if (r_pending) w_next = c_st_load;
            c_st_load:    w_next = c_st_fetch;
            c_st_fetch:   w_next = c_st_wait;
            c_st_wait:    w_next = c_st_present;
            c_st_present: begin
                if (pix_ready) begin
                    if (w_last) begin
                        w_next = c_st_done;
                    end else if (w_need_fetch) begin
                        w_next = c_st_fetch;
                    end
                end
            end
            c_st_done:    w_next = c_st_idle;
            default:      w_next = c_st_idle;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        frame_done  = 1'b0;
        busy        = 1'b0;
        pix_valid   = 1'b0;
        w_start     = 1'b0;
        w_advance   = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            c_st_idle:    w_consume = r_pending;
            c_st_load: begin
                frame_start = 1'b1;
                busy        = 1'b1;
                w_start     = 1'b1;
            end
            c_st_fetch,
            c_st_wait:    busy = 1'b1;
            c_st_present: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
                w_advance = pix_ready;
            end
            c_st_done:    frame_done = 1'b1;
            default:      ;
        endcase
    end

    assign pix_data = r_pix_data;
    assign pix_last = pix_valid && w_last;
    assign rom_addr = w_addr;
    assign cur_img  = r_cur_img;

    ili_scale_addr_gen #(
        .SRC_W  (SRC_W),
        .SRC_H  (SRC_H),
        .SCALE  (SCALE),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .base       (w_base),
        .advance    (w_advance),
        .addr       (w_addr),
        .need_fetch (w_need_fetch),
        .last       (w_last)
    );

endmodule

`default_nettype wire
